// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 Set-2 key decoder.
// States, prefix/status bytes and the tracked-key (ext, code) lookup.
package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } kbd_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ECHO  = 8'hEE;
    localparam logic [7:0] SC_ACK   = 8'hFA;
    localparam logic [7:0] SC_BATF  = 8'hFC;
    localparam logic [7:0] SC_RSND  = 8'hFE;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    localparam logic [2:0] SKIP_LEN = 3'd7;

    localparam int NUM_TRACKED_KEYS = 7;

    typedef enum logic [2:0] {
        KEY_LSHIFT = 3'd0,
        KEY_RSHIFT = 3'd1,
        KEY_SPACE  = 3'd2,
        KEY_ENTER  = 3'd3,
        KEY_P      = 3'd4,
        KEY_LEFT   = 3'd5,
        KEY_RIGHT  = 3'd6
    } key_idx_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_BAT)  || (b == SC_ECHO) ||
               (b == SC_ACK)  || (b == SC_BATF) || (b == SC_RSND) ||
               (b == SC_ERR1);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
    endfunction

    // One-hot bitmap position for a (ext, code) pair; zero if untracked.
    function automatic logic [NUM_TRACKED_KEYS-1:0] key_lookup(
        input logic       ext,
        input logic [7:0] code
    );
        logic [NUM_TRACKED_KEYS-1:0] m;
        m = '0;
        m[KEY_LSHIFT] = !ext && (code == 8'h12);
        m[KEY_RSHIFT] = !ext && (code == 8'h59);
        m[KEY_SPACE]  = !ext && (code == 8'h29);
        m[KEY_ENTER]  = !ext && (code == 8'h5A);
        m[KEY_P]      = !ext && (code == 8'h4D);
        m[KEY_LEFT]   =  ext && (code == 8'h6B);
        m[KEY_RIGHT]  =  ext && (code == 8'h74);
        return m;
    endfunction

endpackage

// File: rtl/kbd_key_tracker.sv
// Pressed/released bitmap of the game control keys.
// Make events set the matching bit, break events clear it.
module kbd_key_tracker
    import kbd_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_fire,
    input  logic [7:0]                  ev_code,
    input  logic                        ev_ext,
    input  logic                        ev_make,
    output logic [NUM_TRACKED_KEYS-1:0] keys_down
);

    logic [NUM_TRACKED_KEYS-1:0] hit;

    assign hit = key_lookup(ev_ext, ev_code);

    // Bitmap register, updated in step with the event strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_down <= '0;
        end else if (ev_fire) begin
            if (ev_make) keys_down <= keys_down | hit;
            else         keys_down <= keys_down & ~hit;
        end
    end

endmodule

// File: rtl/kbd_scan_decoder.sv
// Set-2 scan-code sequence decoder: strips E0/F0, drops Pause/status.
// Optional inter-byte timeout enabled by KBD_SEQ_TIMEOUT_EN.
module kbd_scan_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  din,
    input  logic                        din_new,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic                        key_make,
    output logic                        key_valid,
    output logic [NUM_TRACKED_KEYS-1:0] keys_down,
    output logic                        seq_timeout
);

    kbd_state_t state, state_n;
    logic [2:0] skip_cnt, skip_n;
    logic       ev_fire, ev_ext, ev_make;
    logic       tmo_hit;

`ifdef KBD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmr;

    assign tmo_hit = (state != IDLE) && !din_new && (tmr == TMO_LAST);

    // Inter-byte timer, running only while a sequence is open
    always_ff @(posedge clk) begin
        if (reset || din_new || state == IDLE) tmr <= '0;
        else                                   tmr <= tmr + 1'b1;
    end

    // Abandon strobe, one cycle after expiry
    always_ff @(posedge clk) begin
        if (reset) seq_timeout <= 1'b0;
        else       seq_timeout <= tmo_hit;
    end
`else
    assign tmo_hit     = 1'b0;
    assign seq_timeout = 1'b0;
`endif

    // FSM and Pause skip-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
        end
    end

    // Next-state and event decode for each received byte
    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        ev_fire = 1'b0;
        ev_ext  = 1'b0;
        ev_make = 1'b0;
        if (din_new) begin
            unique case (state)
                IDLE: begin
                    if (din == SC_EXT) begin
                        state_n = EXT;
                    end else if (din == SC_BRK) begin
                        state_n = BRK;
                    end else if (din == SC_PAUSE) begin
                        state_n = SKIP;
                        skip_n  = SKIP_LEN;
                    end else if (!is_status(din)) begin
                        ev_fire = 1'b1;
                        ev_make = 1'b1;
                    end
                end
                EXT: begin
                    if (din == SC_BRK) begin
                        state_n = EXT_BRK;
                    end else if (!is_prefix(din)) begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        ev_make = 1'b1;
                        state_n = IDLE;
                    end
                end
                BRK: begin
                    if (!is_prefix(din)) begin
                        ev_fire = 1'b1;
                        state_n = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (!is_prefix(din)) begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        state_n = IDLE;
                    end
                end
                SKIP: begin
                    skip_n = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_n  = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_n = IDLE;
            skip_n  = '0;
        end
    end

    // Event registers: fields hold until the next event
    always_ff @(posedge clk) begin
        if (reset) begin
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_make  <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= ev_fire;
            if (ev_fire) begin
                key_code <= din;
                key_ext  <= ev_ext;
                key_make <= ev_make;
            end
        end
    end

    kbd_key_tracker u_tracker (
        .clk       (clk),
        .reset     (reset),
        .ev_fire   (ev_fire),
        .ev_code   (din),
        .ev_ext    (ev_ext),
        .ev_make   (ev_make),
        .keys_down (keys_down)
    );

endmodule
